// File: rtl/io_port_pkg.sv
// Shared constants for the memory-mapped I/O port responder.
// Holds the register offsets, the STATUS/CTRL bit positions and the FIFO geometry.
// Imported by io_port_fifo and io_port_responder.
package io_port_pkg;

  // Byte offsets inside the 16-byte window (address bits [1:0] are always ignored)
  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] RXDATA_OFF = 4'h4;
  localparam logic [3:0] STATUS_OFF = 4'h8;
  localparam logic [3:0] CTRL_OFF   = 4'hC;

  // STATUS bit positions
  localparam int ST_COUNT_LSB = 0;
  localparam int ST_FULL      = 3;
  localparam int ST_EMPTY     = 4;
  localparam int ST_OVF       = 5;
  localparam int ST_CHG       = 6;

  // CTRL bit positions
  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_EN_BIT    = 1;

  // Output FIFO geometry; count needs one more bit than the pointers to encode "4"
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/io_port_fifo.sv
// Purpose: 4-entry synchronous FIFO feeding the PortOut handshake.
// Latency: a pushed word is at the head the cycle after the push edge when the FIFO was empty.
// Backpressure: push is dropped when full unless a pop occurs at the same edge; flush beats pop.
// Ports: clk/arst_n, push + push_dat, pop, flush, head_dat (0 when empty), count, full, empty.
module io_port_fifo
  import io_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head_dat,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  do_pop;
  logic                  do_push;

  assign full  = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // When full, a same-edge pop frees the slot the push lands in (wr_ptr == rd_ptr),
  // so overwriting the outgoing head is safe.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + FIFO_PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_responder.sv
// Purpose: MMIO responder (TXDATA/RXDATA/STATUS/CTRL) on the MEM-stage data bus, driving PortOut.
// Latency: ReadData/Hit combinational; push visible on PortOut next cycle; PortIn seen after 2 edges.
// Backpressure: PortOutValid/PortOutReady handshake; stores into a full FIFO are dropped and flag overflow.
// Ports: clk, reset (async active-low), MemWrite/MemRead/Address/WriteData -> ReadData/Hit,
//        PortIn (async), PortOut/PortOutValid/PortOutReady, InChanged (IO_PORT_CHANGE_DETECT_EN only).
module io_port_responder
  import io_port_pkg::*;
#(
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] BASE_ADDR     = 32'h1001_0400,
  parameter int          PORT_IN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic                     MemRead,
  input  logic [31:0]              Address,
  input  logic [DATA_WIDTH-1:0]    WriteData,
  output logic [DATA_WIDTH-1:0]    ReadData,
  output logic                     Hit,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [DATA_WIDTH-1:0]    PortOut,
  output logic                     PortOutValid,
  input  logic                     PortOutReady
`ifdef IO_PORT_CHANGE_DETECT_EN
  ,
  output logic                     InChanged
`endif
);

  logic [3:0]              off;
  logic                    wr_tx;
  logic                    wr_ctrl;
  logic                    rd_status;
  logic                    flush;
  logic                    pop;
  logic                    ovf_set;
  logic                    ctrl_en;
  logic                    overflow;
  logic                    in_changed;
  logic [PORT_IN_WIDTH-1:0] s1;
  logic [PORT_IN_WIDTH-1:0] s2;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   status_word;
  logic [DATA_WIDTH-1:0]   ctrl_word;
  logic [DATA_WIDTH-1:0]   rd_dat;
  logic                    unused_addr_lsbs;

  // Byte lane bits never select anything
  assign unused_addr_lsbs = ^Address[1:0];

  assign Hit = (Address[31:4] == BASE_ADDR[31:4]);
  assign off = {Address[3:2], 2'b00};

  assign wr_tx   = MemWrite & Hit & (off == TXDATA_OFF);
  assign wr_ctrl = MemWrite & Hit & (off == CTRL_OFF);
  // A combined read+write cycle takes the write action only, so no clear-on-read then.
  assign rd_status = MemRead & ~MemWrite & Hit & (off == STATUS_OFF);
  assign flush     = wr_ctrl & WriteData[CTRL_FLUSH_BIT];

  assign PortOutValid = ~fifo_empty & ctrl_en;
  assign pop          = PortOutValid & PortOutReady;
  // Overflow only when the word is really lost: full with no pop freeing a slot.
  assign ovf_set      = wr_tx & fifo_full & ~pop;

  io_port_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .arst_n   (reset),
    .push     (wr_tx),
    .push_dat (WriteData),
    .pop      (pop),
    .flush    (flush),
    .head_dat (PortOut),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_en  <= 1'b0;
      overflow <= 1'b0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en <= WriteData[CTRL_EN_BIT];
      end
      // Set wins over a same-cycle clear-on-read
      overflow <= ovf_set | (overflow & ~rd_status);
      s1       <= PortIn;
      s2       <= s1;
    end
  end

`ifdef IO_PORT_CHANGE_DETECT_EN
  logic [PORT_IN_WIDTH-1:0] s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s3         <= '0;
      in_changed <= 1'b0;
    end else begin
      s3         <= s2;
      in_changed <= (s2 != s3) | (in_changed & ~rd_status);
    end
  end

  assign InChanged = in_changed;
`else
  assign in_changed = 1'b0;
`endif

  always_comb begin
    status_word                                = '0;
    status_word[ST_COUNT_LSB +: FIFO_CNT_W]    = fifo_count;
    status_word[ST_FULL]                       = fifo_full;
    status_word[ST_EMPTY]                      = fifo_empty;
    status_word[ST_OVF]                        = overflow;
    status_word[ST_CHG]                        = in_changed;
  end

  // Flush is self-clearing and always reads back as 0
  always_comb begin
    ctrl_word              = '0;
    ctrl_word[CTRL_EN_BIT] = ctrl_en;
  end

  always_comb begin
    rd_dat = '0;
    if (Hit) begin
      case (off)
        RXDATA_OFF: rd_dat[PORT_IN_WIDTH-1:0] = s2;
        STATUS_OFF: rd_dat = status_word;
        CTRL_OFF:   rd_dat = ctrl_word;
        default:    rd_dat = '0;
      endcase
    end
  end

  assign ReadData = rd_dat;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: register map, FIFO push/pop/overflow/flush,
// PortIn synchronizer timing, sticky flags with clear-on-read, and asynchronous reset.
module tb_io_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0400;
  localparam logic [31:0] TX   = BASE;
  localparam logic [31:0] RX   = BASE + 32'h4;
  localparam logic [31:0] ST   = BASE + 32'h8;
  localparam logic [31:0] CT   = BASE + 32'hC;
`ifdef IO_PORT_CHANGE_DETECT_EN
  localparam logic [31:0] CHG  = 32'h40;
`else
  localparam logic [31:0] CHG  = 32'h00;
`endif

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        PortOutValid;
  logic        PortOutReady;
`ifdef IO_PORT_CHANGE_DETECT_EN
  logic        InChanged;
`endif

  int vectors    = 0;
  int miscompares = 0;

  io_port_responder dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .Address      (Address),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .Hit          (Hit),
    .PortIn       (PortIn),
    .PortOut      (PortOut),
    .PortOutValid (PortOutValid),
    .PortOutReady (PortOutReady)
`ifdef IO_PORT_CHANGE_DETECT_EN
    ,
    .InChanged    (InChanged)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Address   = '0;
    WriteData = '0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Address   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    step();
    idle();
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address  = a;
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    #1;
    check(tag, ReadData, exp);
    step();
    idle();
  endtask

  task automatic drain_chk(input string tag, input logic [31:0] first, input int n);
    PortOutReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, PortOut, first + i);
      step();
    end
    PortOutReady = 1'b0;
    check({tag, "_valid_after"}, {31'b0, PortOutValid}, 32'h0);
  endtask

  initial begin
    reset        = 1'b0;
    PortIn       = 8'h00;
    PortOutReady = 1'b0;
    idle();
    step();
    step();

    // Reset state
    check("rst_portout", PortOut, 32'h0);
    check("rst_valid", {31'b0, PortOutValid}, 32'h0);
    check("rst_readdata", ReadData, 32'h0);
    check("rst_hit", {31'b0, Hit}, 32'h0);
`ifdef IO_PORT_CHANGE_DETECT_EN
    check("rst_inchanged", {31'b0, InChanged}, 32'h0);
`endif
    reset = 1'b1;
    step();
    load_chk("st_after_reset", ST, 32'h10);
    load_chk("ctrl_after_reset", CT, 32'h0);

    // Single store while disabled, then enable
    store(TX, 32'hA5);
    load_chk("st_one", ST, 32'h01);
    check("valid_disabled", {31'b0, PortOutValid}, 32'h0);
    check("head_disabled", PortOut, 32'hA5);
    store(CT, 32'h2);
    check("valid_enabled", {31'b0, PortOutValid}, 32'h1);
    check("head_enabled", PortOut, 32'hA5);
    load_chk("ctrl_en_readback", CT, 32'h2);
    PortOutReady = 1'b1;
    step();
    PortOutReady = 1'b0;
    check("valid_after_pop", {31'b0, PortOutValid}, 32'h0);
    check("head_after_pop", PortOut, 32'h0);
    load_chk("st_empty", ST, 32'h10);

    // Window decode boundaries
    MemRead = 1'b1;
    Address = BASE + 32'h10;
    #1;
    check("hit_above", {31'b0, Hit}, 32'h0);
    check("rd_above", ReadData, 32'h0);
    Address = BASE - 32'h4;
    #1;
    check("hit_below", {31'b0, Hit}, 32'h0);
    Address = BASE + 32'hB;
    #1;
    check("hit_lsbs_ignored", {31'b0, Hit}, 32'h1);
    check("rd_lsbs_ignored", ReadData, 32'h10);
    step();
    idle();
    store(BASE + 32'h10, 32'h77);
    load_chk("st_miss_store", ST, 32'h10);

    // Five stores with Ready low: fourth fills, fifth overflows
    for (int i = 1; i <= 5; i++) store(TX, i);
    load_chk("st_full_ovf", ST, 32'h2C);
    load_chk("st_ovf_cleared", ST, 32'h0C);
    load_chk("tx_reads_zero", TX, 32'h0);
    drain_chk("drain_1to4", 32'h1, 4);
    load_chk("st_drained", ST, 32'h10);

    // Full FIFO: pop and push at the same edge
    for (int i = 5; i <= 8; i++) store(TX, i);
    load_chk("st_full", ST, 32'h0C);
    check("head_before_swap", PortOut, 32'h5);
    PortOutReady = 1'b1;
    Address      = TX;
    WriteData    = 32'h9;
    MemWrite     = 1'b1;
    step();
    PortOutReady = 1'b0;
    idle();
    load_chk("st_swap_no_ovf", ST, 32'h0C);
    drain_chk("drain_6to9", 32'h6, 4);

    // PortIn step through the synchronizer
    PortIn  = 8'h3C;
    Address = RX;
    MemRead = 1'b1;
    #1;
    check("rx_edge0", ReadData, 32'h0);
    step();
    check("rx_edge1", ReadData, 32'h0);
    step();
    check("rx_edge2", ReadData, 32'h3C);
`ifdef IO_PORT_CHANGE_DETECT_EN
    check("inchg_edge2", {31'b0, InChanged}, 32'h0);
`endif
    idle();
    step();
`ifdef IO_PORT_CHANGE_DETECT_EN
    check("inchg_edge3", {31'b0, InChanged}, 32'h1);
`endif
    load_chk("st_inchg", ST, 32'h10 | CHG);
    load_chk("st_inchg_cleared", ST, 32'h10);

    // Overflow clear-on-read, then flush with 3 entries and Ready high
    for (int i = 10; i <= 14; i++) store(TX, i);
    load_chk("st_ovf2", ST, 32'h2C);
    load_chk("st_ovf2_cleared", ST, 32'h0C);
    PortOutReady = 1'b1;
    step();
    PortOutReady = 1'b0;
    check("head_three_left", PortOut, 32'd11);
    load_chk("st_three", ST, 32'h03);
    PortOutReady = 1'b1;
    store(CT, 32'h3);
    PortOutReady = 1'b0;
    check("valid_after_flush", {31'b0, PortOutValid}, 32'h0);
    check("head_after_flush", PortOut, 32'h0);
    load_chk("st_after_flush", ST, 32'h10);
    load_chk("ctrl_flush_selfclear", CT, 32'h2);

    // STATUS read at the same edge in_changed sets: set wins
    PortIn = 8'h3D;
    step();
    step();
    load_chk("st_coincide_pre", ST, 32'h10);
    load_chk("st_coincide_set", ST, 32'h10 | CHG);
    load_chk("st_coincide_clr", ST, 32'h10);

    // Asynchronous reset mid-drain
    for (int i = 20; i <= 22; i++) store(TX, i);
    PortOutReady = 1'b1;
    check("head_pre_reset", PortOut, 32'd20);
    step();
    check("head_mid_drain", PortOut, 32'd21);
    #2;
    reset = 1'b0;
    #1;
    check("arst_portout", PortOut, 32'h0);
    check("arst_valid", {31'b0, PortOutValid}, 32'h0);
`ifdef IO_PORT_CHANGE_DETECT_EN
    check("arst_inchanged", {31'b0, InChanged}, 32'h0);
`endif
    Address = ST;
    MemRead = 1'b1;
    #1;
    check("arst_status", ReadData, 32'h10);
    Address = CT;
    #1;
    check("arst_ctrl", ReadData, 32'h0);
    Address = RX;
    #1;
    check("arst_rx", ReadData, 32'h0);
    PortOutReady = 1'b0;
    idle();
    #1;
    reset = 1'b1;
    step();
    load_chk("st_post_reset", ST, 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
